// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_CLK_DIV_DEFAULT = 434;
  localparam int UART_DATA_BITS       = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the rx pin plus falling-edge detect.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic       s1;
  logic       prev;
  logic [1:0] vld_pipe;

  // prev stays low until the pin value has reached rx_s, so a line that is
  // already low when reset releases is never mistaken for a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      rx_s     <= 1'b1;
      prev     <= 1'b0;
      vld_pipe <= '0;
    end else begin
      s1       <= rx;
      rx_s     <= s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
      prev     <= vld_pipe[1] & rx_s;
    end
  end

  assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD = CW'(CLK_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_START = 2'(START);
  localparam logic [1:0] ST_DATA  = 2'(DATA);
  localparam logic [1:0] ST_STOP  = 2'(STOP);

  logic                      rx_s;
  logic                      fall;
  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      tick;
  logic                      dec;
  logic                      bit_val;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign tick = (state != ST_IDLE) && (cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  logic       dec_pend;

  // Decide one clock after expiry so the expiry+1 sample is available.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist     <= 2'b11;
      dec_pend <= 1'b0;
    end else begin
      hist     <= {hist[0], rx_s};
      dec_pend <= tick;
    end
  end

  assign dec     = dec_pend;
  assign bit_val = maj3(hist[1], hist[0], rx_s);
`else
  assign dec     = tick;
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      dout      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      // Counter reloads at every expiry so bit spacing never depends on the decision path.
      if (state == ST_IDLE) begin
        if (fall) begin
          cnt     <= HALF_LD;
          bit_idx <= '0;
          state   <= ST_START;
        end
      end else begin
        cnt <= tick ? FULL_LD : cnt - 1'b1;
      end

      if (dec) begin
        case (state)
          ST_START: state <= bit_val ? ST_IDLE : ST_DATA;
          ST_DATA: begin
            shift   <= {bit_val, shift[UART_DATA_BITS-1:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) state <= ST_STOP;
          end
          ST_STOP: begin
            dout      <= shift;
            valid     <= bit_val;
            frame_err <= ~bit_val;
            state     <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
